// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: request handshake with operands,
// synchronous flush, and the registered result handshake.
interface alu_multicycle_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle basic ops, XLEN-cycle shift-add multiply
// and XLEN-cycle restoring divide on operand magnitudes, with a sign-fix cycle.
module alu_multicycle #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_multicycle_if.slave  io
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                is_div_q, is_div_d;
  logic                sel_lo_q, sel_lo_d;

  logic                accept, is_mul, is_div, a_sgn, b_sgn, sa, sb;
  logic                div_zero, div_ovf;
  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     mag_a, mag_b, basic_res, bypass_res;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     div_sel, fix_res;

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = result_q;

  assign accept = io.in_valid && (state_q == IDLE) && !io.flush;
  assign is_mul = (io.op[4:2] == 3'b100);
  assign is_div = (io.op[4:2] == 3'b101);
  // mul/mulh: s*s, mulhsu: s*u, mulhu: u*u; div/rem signed, divu/remu unsigned
  assign a_sgn  = (is_mul && (io.op[1:0] != 2'b11)) || (is_div && !io.op[0]);
  assign b_sgn  = (is_mul && !io.op[1]) || (is_div && !io.op[0]);
  assign sa     = a_sgn && io.a[XLEN-1];
  assign sb     = b_sgn && io.b[XLEN-1];
  assign mag_a  = sa ? -io.a : io.a;
  assign mag_b  = sb ? -io.b : io.b;
  assign shamt  = io.b[SHW-1:0];

  assign div_zero   = is_div && (io.b == '0);
  assign div_ovf    = is_div && !io.op[0] && (io.a == {1'b1, {(XLEN-1){1'b0}}}) && (io.b == '1);
  assign bypass_res = div_zero ? (io.op[1] ? io.a : '1) : (io.op[1] ? '0 : io.a);

  // One shift-add step: conditionally add multiplicand into the upper half, shift right
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // One restoring step: upper half is the partial remainder, lower half the dividend/quotient
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // Multiply negates the full product before selecting a half; divide negates the chosen half
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign div_sel  = sel_lo_q ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
  assign fix_res  = is_div_q ? (neg_q ? -div_sel : div_sel)
                             : (sel_lo_q ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  // Single-cycle operations and undefined codes
  always_comb begin
    basic_res = '0;
    case (io.op)
      5'b00000: basic_res = io.a + io.b;
      5'b00001: basic_res = io.a - io.b;
      5'b00010: basic_res = io.b;
      5'b00011: basic_res = io.a & io.b;
      5'b00100: basic_res = io.a ^ io.b;
      5'b00101: basic_res = io.a | io.b;
      5'b00110: basic_res = io.a << shamt;
      5'b00111: basic_res = io.a >> shamt;
      5'b01000: basic_res = $signed(io.a) >>> shamt;
      5'b01001: basic_res = {{(XLEN-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
      5'b01010: basic_res = {{(XLEN-1){1'b0}}, (io.a < io.b)};
      default:  basic_res = '0;
    endcase
  end

  // Next-state and datapath update; flush overrides every state
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    sel_lo_d = sel_lo_q;
    if (io.flush) begin
      state_d  = IDLE;
      acc_d    = '0;
      opnd_d   = '0;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_d  = MUL;
              acc_d    = {{XLEN{1'b0}}, mag_b};
              opnd_d   = mag_a;
              cnt_d    = '0;
              neg_d    = sa ^ sb;
              is_div_d = 1'b0;
              sel_lo_d = (io.op[1:0] == 2'b00);
            end else if (is_div && !div_zero && !div_ovf) begin
              state_d  = DIV;
              acc_d    = {{XLEN{1'b0}}, mag_a};
              opnd_d   = mag_b;
              cnt_d    = '0;
              neg_d    = io.op[1] ? sa : (sa ^ sb);
              is_div_d = 1'b1;
              sel_lo_d = !io.op[1];
            end else if (is_div) begin
              state_d  = DONE;
              result_d = bypass_res;
            end else begin
              state_d  = DONE;
              result_d = basic_res;
            end
          end
        end
        MUL: begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            state_d = FIX;
            cnt_d   = '0;
          end
        end
        DIV: begin
          acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            state_d = FIX;
            cnt_d   = '0;
          end
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE: begin
          if (io.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      sel_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      sel_lo_q <= sel_lo_d;
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at XLEN=32.
module tb_alu_multicycle;
  localparam int XLEN = 32;
  localparam logic [4:0] OPS [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                      5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22,
                                      5'd23, 5'd15};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_multicycle_if #(.XLEN(XLEN)) bus ();
  alu_multicycle #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = b;
      5'd3:  r = a & b;
      5'd4:  r = a ^ b;
      5'd5:  r = a | b;
      5'd6:  r = a << b[4:0];
      5'd7:  r = a >> b[4:0];
      5'd8:  r = $signed(a) >>> b[4:0];
      5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10: r = (a < b) ? 32'd1 : 32'd0;
      5'd16: begin p = sa * sb; r = p[31:0]; end
      5'd17: begin p = sa * sb; r = p[63:32]; end
      5'd18: begin p = sa * ub; r = p[63:32]; end
      5'd19: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      5'd20: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      5'd23: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4:2] == 3'b100) return XLEN + 2;
    if (op[4:2] == 3'b101) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
    end
    return 1;
  endfunction

  // Present a request, wait (bounded) for acceptance, then scramble operands.
  // Returns at the negedge following the accepting edge.
  task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
    int waited;
    sb_q.push_back('{res: exp, lat: lat});
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  // Cycles from the accepting edge until out_valid is seen; -1 when the bound expires.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic set_vec(input int i, input string name, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    vecs[i] = '{name: name, op: op, a: a, b: b, exp: exp, lat: lat};
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'd0)
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h expected rdy=1 busy=0 vld=0 res=0",
               bus.in_ready, bus.busy, bus.out_valid, bus.result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int   lat;
    exp_t e;
    set_vec(0,  "add_ovf",  5'd0,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1);
    set_vec(1,  "slt",      5'd9,  32'hFFFF_FFFF, 32'h0,          32'h1,         1);
    set_vec(2,  "sltu",     5'd10, 32'hFFFF_FFFF, 32'h0,          32'h0,         1);
    set_vec(3,  "sra",      5'd8,  32'h8000_0000, 32'h24,         32'hF800_0000, 1);
    set_vec(4,  "sll32",    5'd6,  32'h1234_5678, 32'd32,         32'h1234_5678, 1);
    set_vec(5,  "mulh",     5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         34);
    set_vec(6,  "mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 34);
    set_vec(7,  "div_neg",  5'd20, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34);
    set_vec(8,  "rem_neg",  5'd22, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34);
    set_vec(9,  "divu_z",   5'd21, 32'd5,         32'd0,          32'hFFFF_FFFF, 1);
    set_vec(10, "div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1);
    set_vec(11, "undef",    5'd15, 32'h1234_5678, 32'h9ABC_DEF0,  32'h0,         1);
    for (int i = 0; i < 12; i++) begin
      drive_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      wait_out(lat);
      e = sb_q.pop_front();
      n_checks++;
      if (bus.result !== e.res)
        $display("FAIL %s result: got %h expected %h", vecs[i].name, bus.result, e.res);
      else n_pass++;
      n_checks++;
      if (lat != e.lat)
        $display("FAIL %s latency: got %0d expected %0d", vecs[i].name, lat, e.lat);
      else n_pass++;
      consume();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL %s release: got vld=%b rdy=%b expected vld=0 rdy=1",
                 vecs[i].name, bus.out_valid, bus.in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int          lat, sel;
    logic [4:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    for (int i = 0; i < 30; i++) begin
      op  = OPS[$urandom_range(0, 19)];
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 100);
      drive_req(op, a, b, model_res(op, a, b), model_lat(op, a, b));
      wait_out(lat);
      e = sb_q.pop_front();
      n_checks++;
      if (bus.result !== e.res || lat != e.lat)
        $display("FAIL rand op=%0d a=%h b=%h: got res=%h lat=%0d expected res=%h lat=%0d",
                 op, a, b, bus.result, lat, e.res, e.lat);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_hold();
    int   lat;
    bit   ok;
    exp_t e;
    drive_req(5'd4, 32'hA5A5_0F0F, 32'h0FF0_1234, 32'hAA55_1D3B, 1);
    wait_out(lat);
    e = sb_q.pop_front();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.result !== e.res || bus.in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || bus.result !== e.res)
      $display("FAIL hold: got vld=%b res=%h rdy=%b expected vld=1 res=%h rdy=0",
               bus.out_valid, bus.result, bus.in_ready, e.res);
    else n_pass++;
    // Release and present a new request in the same cycle; it must wait one edge.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 5'd0;
    bus.a = 32'd2;
    bus.b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL hold_release: got vld=%b rdy=%b expected vld=0 rdy=1", bus.out_valid, bus.in_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5)
      $display("FAIL hold_next_accept: got vld=%b res=%h expected vld=1 res=00000005",
               bus.out_valid, bus.result);
    else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_req(5'd1, 32'd100 + i, 32'd1, 32'd99 + i, 1);
      wait_out(lat);
      e = sb_q.pop_front();
      // out_ready asserted together with the result: no dead cycle beyond the return to IDLE
      bus.out_ready = 1'b1;
      n_checks++;
      if (bus.result !== e.res || lat != e.lat)
        $display("FAIL b2b_%0d: got res=%h lat=%0d expected res=%h lat=%0d", i, bus.result, lat, e.res, e.lat);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_flush();
    int   lat;
    bit   seen;
    drive_req(5'd20, 32'd1000, 32'd7, 32'd142, 34);
    for (int i = 1; i < 10; i++) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    void'(sb_q.pop_front());
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL flush_div: got busy=%b rdy=%b vld=%b expected busy=0 rdy=1 vld=0",
               bus.busy, bus.in_ready, bus.out_valid);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) $display("FAIL flush_no_result: got out_valid=1 expected out_valid=0");
    else n_pass++;
    // flush with a request in IDLE must not accept it
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    bus.op = 5'd0;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL flush_idle_req: got busy=%b vld=%b expected busy=0 vld=0", bus.busy, bus.out_valid);
    else n_pass++;
    // flush drops a pending result in DONE
    drive_req(5'd5, 32'hF0, 32'h0F, 32'hFF, 1);
    wait_out(lat);
    void'(sb_q.pop_front());
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++;
    if (lat != 1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_done: got lat=%0d vld=%b rdy=%b expected lat=1 vld=0 rdy=1",
               lat, bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   lat;
    exp_t e;
    drive_req(5'd3, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1);
    wait_out(lat);
    void'(sb_q.pop_front());
    consume();
    drive_req(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'd0)
      $display("FAIL reset_mid_mul: got rdy=%b busy=%b vld=%b res=%h expected rdy=1 busy=0 vld=0 res=0",
               bus.in_ready, bus.busy, bus.out_valid, bus.result);
    else n_pass++;
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_req(5'd16, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFD6, 34);
    wait_out(lat);
    e = sb_q.pop_front();
    n_checks++;
    if (bus.result !== e.res || lat != e.lat)
      $display("FAIL mul_after_reset: got res=%h lat=%0d expected res=%h lat=%0d", bus.result, lat, e.res, e.lat);
    else n_pass++;
    consume();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
